// File: rtl/apb_master_ctrl.sv
// APB master sequencer: pops command entries from the write FIFO, runs one APB
// SETUP/ACCESS transfer per entry and pushes read results into the read FIFO.
module apb_master_ctrl #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       control,
  input  logic              wfifo_empty,
  input  logic [63:0]       wfifo_rdata,
  output logic              wfifo_ren,
  input  logic              rfifo_full,
  output logic              rfifo_wen,
  output logic [63:0]       rfifo_wdata,
  output logic [3:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [1:0]        apb_state,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, PUSH} state_e;

  state_e            state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  waitCnt_q;
  logic [33:0]       result_q;
  logic [7:0]        errCnt_q;

  logic       pop;
  logic       timeoutHit;
  logic       done;
  logic       errEvent;
  logic [3:0] selDecode;
  logic       unusedBits;

  assign pop        = (state_q == IDLE) && control[0] && !wfifo_empty;
  assign timeoutHit = (state_q == ACCESS) && !pready && (waitCnt_q == LAST_CNT);
  assign done       = (state_q == ACCESS) && (pready || timeoutHit);
  assign errEvent   = done && (timeoutHit || (pready && pslverr));
  assign selDecode  = 4'b0001 << addr_q[ADDR_W-1 -: 2];
  assign unusedBits = ^{control[63:1], wfifo_rdata[62:32+ADDR_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = write_q ? IDLE : PUSH;
      PUSH:    if (!rfifo_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wfifo_ren = 1'b0;
    rfifo_wen = 1'b0;
    psel      = 4'b0000;
    penable   = 1'b0;
    apb_state = write_q ? 2'd3 : 2'd2;
    case (state_q)
      IDLE: begin
        wfifo_ren = pop;
        apb_state = control[0] ? 2'd1 : 2'd0;
      end
      SETUP:  psel = selDecode;
      ACCESS: begin
        psel    = selDecode;
        penable = 1'b1;
      end
      PUSH:    rfifo_wen = !rfifo_full;
      default: ;
    endcase
  end

  // A timed-out transfer reports prdata = 0 and pslverr = 0 with the timeout flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      waitCnt_q <= '0;
      result_q  <= '0;
      errCnt_q  <= '0;
    end else begin
      if (pop) begin
        write_q <= wfifo_rdata[63];
        addr_q  <= wfifo_rdata[32 +: ADDR_W];
        wdata_q <= wfifo_rdata[31:0];
      end
      if (state_q == SETUP)       waitCnt_q <= '0;
      else if (state_q == ACCESS) waitCnt_q <= waitCnt_q + CNT_W'(1);
      if (done) result_q <= {timeoutHit, pready & pslverr, pready ? prdata : 32'h0};
      if (errEvent && (errCnt_q != 8'hFF)) errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign pwrite      = write_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign rfifo_wdata = {30'h0, result_q};
  assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: write-FIFO model, reactive APB slave
// and a scoreboard of expected read-FIFO pushes.
module tb_apb_master_ctrl;

  localparam logic [63:0] CTRL_ON  = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] CTRL_OFF = 64'hA5A5_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] control;
  logic        wfifo_empty = 1'b1;
  logic [63:0] wfifo_rdata = 64'h0;
  logic        wfifo_ren;
  logic        rfifo_full;
  logic        rfifo_wen;
  logic [63:0] rfifo_wdata;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [23:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [1:0]  apb_state;
  logic [7:0]  err_cnt;

  logic [63:0] wq[$];
  logic [63:0] expQ[$];
  int          compareCount = 0;
  int          mismatchCount = 0;
  int          pushCount = 0;
  int          errExp = 0;
  int          waitStates = 0;
  int          accessCnt = 0;
  bit          hang = 1'b0;
  bit          slvErr = 1'b0;
  logic [31:0] rdataVal = 32'h0;
  logic        renSeen;
  logic [63:0] dropped;

  apb_master_ctrl #(.ADDR_W(24), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .control(control),
    .wfifo_empty(wfifo_empty), .wfifo_rdata(wfifo_rdata), .wfifo_ren(wfifo_ren),
    .rfifo_full(rfifo_full), .rfifo_wen(rfifo_wen), .rfifo_wdata(rfifo_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .apb_state(apb_state), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [23:0] addr, input logic [31:0] data);
    wq.push_back({wr, 7'h0, addr, data});
    if (!wr) expQ.push_back(hang ? 64'h0000_0002_0000_0000 : {30'h0, 1'b0, slvErr, rdataVal});
    if ((hang || slvErr) && errExp < 255) errExp++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitRen();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wfifo_ren) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("renBound", {63'h0, seen}, 64'h1);
  endtask

  task automatic waitQuiet(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && apb_state < 2'd2 && !wfifo_ren) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("quietBound", {63'h0, ok}, 64'h1);
  endtask

  // Pops take effect just after the clock edge that the DUT used to capture the head.
  always begin
    @(negedge clk);
    #4 renSeen = wfifo_ren;
    @(posedge clk);
    #1;
    if (renSeen && wq.size() > 0) dropped = wq.pop_front();
    wfifo_empty = (wq.size() == 0);
    wfifo_rdata = (wq.size() == 0) ? 64'h0 : wq[0];
  end

  always @(negedge clk) begin
    if (penable && psel != 4'b0000) begin
      pready = !hang && (accessCnt == waitStates);
      accessCnt++;
    end else begin
      pready = 1'b0;
      accessCnt = 0;
    end
    prdata  = rdataVal;
    pslverr = slvErr;
  end

  always @(negedge clk) begin
    if (rfifo_wen) begin
      pushCount++;
      checkOutput("pushWhileFull", {63'h0, rfifo_full}, 64'h0);
      if (expQ.size() == 0) checkOutput("unexpectedPush", {63'h0, rfifo_wen}, 64'h0);
      else checkOutput("rfifoData", rfifo_wdata, expQ.pop_front());
    end
    if (wfifo_ren) checkOutput("popWhileEmpty", {63'h0, wfifo_empty}, 64'h0);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int cnt;
    rst_n = 1'b0;
    control = CTRL_OFF;
    rfifo_full = 1'b0;
    tick(3);
    checkOutput("rstPsel", {60'h0, psel}, 64'h0);
    checkOutput("rstPenable", {63'h0, penable}, 64'h0);
    checkOutput("rstPwrite", {63'h0, pwrite}, 64'h0);
    checkOutput("rstPaddr", {40'h0, paddr}, 64'h0);
    checkOutput("rstPwdata", {32'h0, pwdata}, 64'h0);
    checkOutput("rstRfifoWen", {63'h0, rfifo_wen}, 64'h0);
    checkOutput("rstRfifoWdata", rfifo_wdata, 64'h0);
    checkOutput("rstErrCnt", {56'h0, err_cnt}, 64'h0);
    checkOutput("rstWfifoRen", {63'h0, wfifo_ren}, 64'h0);
    checkOutput("rstState", {62'h0, apb_state}, 64'h0);
    rst_n = 1'b1;
    control = CTRL_ON;
    tick(2);

    $display("[TB] zero-wait write");
    base = pushCount;
    applyStimulus(1'b1, 24'h400010, 32'hDEADBEEF);
    waitRen();
    checkOutput("wrStateN", {62'h0, apb_state}, 64'h1);
    tick(1);
    checkOutput("wrPsel", {60'h0, psel}, 64'h2);
    checkOutput("wrPwrite", {63'h0, pwrite}, 64'h1);
    checkOutput("wrPaddr", {40'h0, paddr}, 64'h400010);
    checkOutput("wrPwdata", {32'h0, pwdata}, 64'hDEADBEEF);
    checkOutput("wrSetupPenable", {63'h0, penable}, 64'h0);
    checkOutput("wrStateBusy", {62'h0, apb_state}, 64'h3);
    tick(1);
    checkOutput("wrAccessPenable", {63'h0, penable}, 64'h1);
    checkOutput("wrAccessPsel", {60'h0, psel}, 64'h2);
    tick(1);
    checkOutput("wrBackIdle", {62'h0, apb_state}, 64'h1);
    checkOutput("wrIdlePsel", {60'h0, psel}, 64'h0);
    checkOutput("wrNoPush", 64'(pushCount - base), 64'h0);

    $display("[TB] read with two wait states");
    waitStates = 2;
    rdataVal = 32'h12345678;
    base = pushCount;
    applyStimulus(1'b0, 24'hC00004, 32'h0);
    waitRen();
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (psel == 4'b1000) cnt++;
      if (i == 1) checkOutput("rdState", {62'h0, apb_state}, 64'h2);
    end
    checkOutput("rdPselCycles", 64'(cnt), 64'd4);
    checkOutput("rdPushOnce", 64'(pushCount - base), 64'h1);
    waitStates = 0;

    $display("[TB] access timeout");
    hang = 1'b1;
    base = pushCount;
    applyStimulus(1'b0, 24'h000040, 32'h0);
    waitRen();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (penable) cnt++;
    end
    checkOutput("toAccessCycles", 64'(cnt), 64'd16);
    checkOutput("toErrCnt", {56'h0, err_cnt}, 64'(errExp));
    checkOutput("toPushOnce", 64'(pushCount - base), 64'h1);
    hang = 1'b0;

    $display("[TB] read FIFO backpressure");
    rdataVal = 32'hCAFE0001;
    rfifo_full = 1'b1;
    applyStimulus(1'b0, 24'h000100, 32'h0);
    applyStimulus(1'b1, 24'h800020, 32'h5555AAAA);
    waitRen();
    base = pushCount;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bpHoldWen", {63'h0, rfifo_wen}, 64'h0);
      checkOutput("bpHoldRen", {63'h0, wfifo_ren}, 64'h0);
      checkOutput("bpHoldState", {62'h0, apb_state}, 64'h2);
      tick(1);
    end
    @(posedge clk);
    #1 rfifo_full = 1'b0;
    #1;
    checkOutput("bpWenAtK", {63'h0, rfifo_wen}, 64'h1);
    checkOutput("bpNoPopAtK", {63'h0, wfifo_ren}, 64'h0);
    tick(2);
    checkOutput("bpPopAtK1", {63'h0, wfifo_ren}, 64'h1);
    checkOutput("bpPushOnce", 64'(pushCount - base), 64'h1);
    waitQuiet(50);

    $display("[TB] enable gating");
    control = CTRL_OFF;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'h000010 + 24'(i), 32'(i));
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("offNoPop", {63'h0, wfifo_ren}, 64'h0);
      checkOutput("offState", {62'h0, apb_state}, 64'h0);
    end
    control = CTRL_ON;
    #1;
    cnt = wfifo_ren ? 1 : 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (wfifo_ren) cnt++;
    end
    tick(1);
    checkOutput("en3Pops", 64'(cnt), 64'd3);
    checkOutput("en3Idle", {62'h0, apb_state}, 64'h1);
    checkOutput("en3Drained", 64'(wq.size()), 64'h0);

    waitStates = 2;
    applyStimulus(1'b1, 24'hC00008, 32'h1);
    applyStimulus(1'b1, 24'hC0000C, 32'h2);
    waitRen();
    tick(2);
    checkOutput("clrInAccess", {63'h0, penable}, 64'h1);
    control = CTRL_OFF;
    tick(2);
    checkOutput("clrStillAccess", {63'h0, penable}, 64'h1);
    tick(1);
    checkOutput("clrState", {62'h0, apb_state}, 64'h0);
    checkOutput("clrPsel", {60'h0, psel}, 64'h0);
    tick(2);
    checkOutput("clrNoPop", {63'h0, wfifo_ren}, 64'h0);
    checkOutput("clrQueued", 64'(wq.size()), 64'h1);
    waitStates = 0;
    control = CTRL_ON;
    waitQuiet(50);

    $display("[TB] slave errors and saturation");
    slvErr = 1'b1;
    applyStimulus(1'b1, 24'h400000, 32'h00000BAD);
    waitQuiet(20);
    checkOutput("errOne", {56'h0, err_cnt}, 64'(errExp));
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 24'(i), 32'(i));
    waitQuiet(1000);
    checkOutput("errSaturate", {56'h0, err_cnt}, 64'(errExp));
    slvErr = 1'b0;

    $display("[TB] reset during access");
    hang = 1'b1;
    base = pushCount;
    applyStimulus(1'b0, 24'h400080, 32'h0);
    waitRen();
    tick(4);
    checkOutput("rstMidPenableBefore", {63'h0, penable}, 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidPsel", {60'h0, psel}, 64'h0);
    checkOutput("rstMidPenable", {63'h0, penable}, 64'h0);
    checkOutput("rstMidErrCnt", {56'h0, err_cnt}, 64'h0);
    errExp = 0;
    expQ.delete();
    hang = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    checkOutput("rstMidNoPush", 64'(pushCount - base), 64'h0);
    checkOutput("rstMidIdle", {62'h0, apb_state}, 64'h1);
    checkOutput("rstMidErrAfter", {56'h0, err_cnt}, 64'(errExp));

    checkOutput("pendingReads", 64'(expQ.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
